// File: rtl/ahb_rr_burst_arbiter_pkg.sv
// Shared encodings for the AHB round-robin burst arbiter: HTRANS/HBURST codes,
// FSM state type, grant limit and the fixed-burst beat-count helper.
package ahb_rr_burst_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [3:0] GRANT_LIMIT = 4'd8;

    typedef enum logic [1:0] {
        ST_NOPORT = 2'd0,
        ST_OWNED  = 2'd1,
        ST_BURST  = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_t;

    // Beats remaining after the NONSEQ beat; 0 means not a fixed-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            HBURST_SINGLE, HBURST_INCR:   return 4'd0;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_burst_arbiter_pick.sv
// Combinational round-robin search: first requester starting at last_owner+1 (mod 4).
module ahb_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last_owner,
    output logic [1:0] index,
    output logic       valid
);

    logic [1:0] cand;

    always_comb begin
        index = 2'd0;
        valid = 1'b0;
        cand  = 2'd0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int i = 4; i >= 1; i--) begin
            cand = last_owner + 2'(i);
            if (req[cand]) begin
                index = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// AHB output-stage arbiter: sticky round-robin grant with fixed-burst and lock holding.
// Optional NONSEQ grant limit enabled by defining ARB_GRANT_LIMIT_EN.
//
// state     | meaning
// ST_NOPORT | no port selected, no_port=1
// ST_OWNED  | port granted, re-arbitrated on every ready cycle
// ST_BURST  | fixed-length burst in flight, grant frozen until beat counter hits 0
// ST_LOCKED | locked sequence, grant frozen until HMASTLOCKM drops
module ahb_rr_burst_arbiter
    import ahb_rr_burst_arbiter_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [3:0] req_port,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [1:0] addr_in_port,
    output logic       no_port,
    output logic       burst_hold
);

    arb_state_t state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [3:0] beat_q, beat_d;
    logic       no_port_q, no_port_d;
    logic       burst_hold_q, burst_hold_d;

    logic [1:0] pick_index;
    logic       pick_valid;
    logic       owner_active, burst_start, arb_point, limit_cut, keep_owner;

    ahb_rr_pick u_pick (
        .req        (req_port),
        .last_owner (last_q),
        .index      (pick_index),
        .valid      (pick_valid)
    );

    assign owner_active = req_port[owner_q] | (HSELM & (HTRANSM != HTRANS_IDLE));
    assign burst_start  = (HTRANSM == HTRANS_NONSEQ) & (burst_beats(HBURSTM) != 4'd0);
    // LOCKED only reaches here when HMASTLOCKM=0, i.e. on the release cycle.
    assign arb_point    = (state_q != ST_BURST) | (beat_q == 4'd0) |
                          (HTRANSM == HTRANS_IDLE) | (HTRANSM == HTRANS_NONSEQ);

`ifdef ARB_GRANT_LIMIT_EN
    logic [3:0] gcnt_q;
    logic       others_req, grant_change;

    assign others_req   = |(req_port & ~(4'b0001 << owner_q));
    // Starting a fixed burst is never cut, so the burst runs to completion.
    assign limit_cut    = (gcnt_q >= GRANT_LIMIT) & others_req & ~burst_start;
    assign grant_change = ~HMASTLOCKM & arb_point & ~keep_owner & pick_valid;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gcnt_q <= 4'd0;
        end else if (HREADYM) begin
            if (grant_change)
                gcnt_q <= 4'd0;
            else if ((HTRANSM == HTRANS_NONSEQ) && (gcnt_q != 4'hF))
                gcnt_q <= gcnt_q + 4'd1;
        end
    end
`else
    assign limit_cut = 1'b0;
`endif

    assign keep_owner = owner_active & ~limit_cut;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        beat_d       = beat_q;
        no_port_d    = no_port_q;
        burst_hold_d = burst_hold_q;
        if (HMASTLOCKM) begin
            state_d      = ST_LOCKED;
            beat_d       = 4'd0;
            burst_hold_d = 1'b0;
        end else if (arb_point) begin
            beat_d       = 4'd0;
            burst_hold_d = 1'b0;
            if (keep_owner) begin
                no_port_d = 1'b0;
                if (burst_start) begin
                    state_d      = ST_BURST;
                    beat_d       = burst_beats(HBURSTM);
                    burst_hold_d = 1'b1;
                end else begin
                    state_d = ST_OWNED;
                end
            end else if (pick_valid) begin
                owner_d   = pick_index;
                last_d    = pick_index;
                no_port_d = 1'b0;
                state_d   = ST_OWNED;
            end else if (HSELM && !no_port_q) begin
                state_d = ST_OWNED;
            end else begin
                state_d   = ST_NOPORT;
                no_port_d = 1'b1;
            end
        end else begin
            case (HTRANSM)
                HTRANS_SEQ:  beat_d = beat_q - 4'd1;
                HTRANS_BUSY: beat_d = beat_q;
                default:     beat_d = beat_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_NOPORT;
            owner_q      <= 2'd0;
            last_q       <= 2'd3;
            beat_q       <= 4'd0;
            no_port_q    <= 1'b1;
            burst_hold_q <= 1'b0;
        end else if (HREADYM) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            beat_q       <= beat_d;
            no_port_q    <= no_port_d;
            burst_hold_q <= burst_hold_d;
        end
    end

    assign addr_in_port = owner_q;
    assign no_port      = no_port_q;
    assign burst_hold   = burst_hold_q;

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// Self-checking bench for ahb_rr_burst_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_ahb_rr_burst_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] req_port;
    logic       HREADYM, HSELM, HMASTLOCKM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [1:0] addr_in_port;
    logic       no_port, burst_hold;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_owner, m_last, m_beats, m_gcount;
    bit m_noport, m_hold;

`ifdef ARB_GRANT_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0] r;
        logic       rdy;
        logic       sel;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       lk;
        int         eo;
        logic       enp;
        logic       eh;
    } vec_t;

    ahb_rr_burst_arbiter dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .burst_hold   (burst_hold)
    );

    always #5 HCLK = ~HCLK;

    task automatic model_reset();
        m_owner = 0; m_last = 3; m_beats = 0; m_gcount = 0;
        m_noport = 1'b1; m_hold = 1'b0;
    endtask

    // Predicts the effect of the coming rising edge from the inputs currently driven.
    task automatic model_edge();
        bit active, fixed, cut, change;
        int len, found, p;
        if (HREADYM !== 1'b1) return;
        fixed  = (HTRANSM == 2'b10) && (HBURSTM >= 3'd2);
        len    = (HBURSTM >= 3'd6) ? 16 : (HBURSTM >= 3'd4) ? 8 : 4;
        change = 1'b0;
        if (HMASTLOCKM) begin
            m_hold = 1'b0; m_beats = 0;
        end else if (m_hold && m_beats > 0 && (HTRANSM == 2'b11 || HTRANSM == 2'b01)) begin
            if (HTRANSM == 2'b11) m_beats = m_beats - 1;
        end else begin
            active = req_port[m_owner] || (HSELM && HTRANSM != 2'b00);
            cut = 1'b0;
            if (LIMIT_ON)
                cut = (m_gcount >= 8) && ((req_port & ~(4'b0001 << m_owner)) != 4'b0) && !fixed;
            m_hold = 1'b0; m_beats = 0;
            if (active && !cut) begin
                m_noport = 1'b0;
                if (fixed) begin m_hold = 1'b1; m_beats = len - 1; end
            end else begin
                found = -1;
                for (int k = 1; k <= 4; k++) begin
                    p = (m_last + k) % 4;
                    if (found < 0 && req_port[p]) found = p;
                end
                if (found >= 0) begin
                    m_owner = found; m_last = found; m_noport = 1'b0; change = 1'b1;
                end else if (!(HSELM && !m_noport)) begin
                    m_noport = 1'b1;
                end
            end
        end
        if (change) m_gcount = 0;
        else if (HTRANSM == 2'b10 && m_gcount < 15) m_gcount = m_gcount + 1;
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy, input logic sel,
                         input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        req_port = r; HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
        model_edge();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        req_port = 4'b0; HREADYM = 1'b1; HSELM = 1'b0; HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({addr_in_port, no_port, burst_hold} !== {2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got addr=%0d no_port=%b hold=%b, want addr=0 no_port=1 hold=0", addr_in_port, no_port, burst_hold);
        end
        drive(4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        vectors++;
        if ({addr_in_port, no_port, burst_hold} !== {2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_idle: got addr=%0d no_port=%b hold=%b, want addr=0 no_port=1 hold=0", addr_in_port, no_port, burst_hold);
        end
    endtask

    task automatic test_round_robin();
        vec_t t[$];
        do_reset();
        t.push_back('{4'b1010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1, 1'b0, 1'b0});
        t.push_back('{4'b1001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 3, 1'b0, 1'b0});
        t.push_back('{4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 3, 1'b1, 1'b0});
        t.push_back('{4'b0001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1'b0, 1'b0});
        t.push_back('{4'b0001, 1'b1, 1'b1, 2'b10, 3'b001, 1'b0, 0, 1'b0, 1'b0});
        t.push_back('{4'b0000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 0, 1'b0, 1'b0});
        t.push_back('{4'b0110, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1'b0, 1'b0});
        t.push_back('{4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1'b1, 1'b0});
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i].r, t[i].rdy, t[i].sel, t[i].tr, t[i].bu, t[i].lk);
            vectors++;
            if ({addr_in_port, no_port, burst_hold} !== {2'(t[i].eo), t[i].enp, t[i].eh}) begin
                miscompares++;
                $display("FAIL rr_step%0d: got addr=%0d no_port=%b hold=%b, want addr=%0d no_port=%b hold=%b", i, addr_in_port, no_port, burst_hold, t[i].eo, t[i].enp, t[i].eh);
            end
        end
    endtask

    task automatic test_burst();
        vec_t t[$];
        do_reset();
        t.push_back('{4'b0001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1'b0, 1'b0});
        t.push_back('{4'b0110, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 0, 1'b0, 1'b1});
        t.push_back('{4'b0110, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 0, 1'b0, 1'b1});
        t.push_back('{4'b0110, 1'b1, 1'b1, 2'b01, 3'b011, 1'b0, 0, 1'b0, 1'b1});
        t.push_back('{4'b0110, 1'b0, 1'b1, 2'b11, 3'b011, 1'b0, 0, 1'b0, 1'b1});
        t.push_back('{4'b0110, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 0, 1'b0, 1'b1});
        t.push_back('{4'b0110, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 0, 1'b0, 1'b1});
        t.push_back('{4'b0110, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1, 1'b0, 1'b0});
        // early termination: owner 1 starts INCR8, aborts with IDLE after one SEQ
        t.push_back('{4'b0101, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0, 1, 1'b0, 1'b1});
        t.push_back('{4'b0101, 1'b1, 1'b1, 2'b11, 3'b101, 1'b0, 1, 1'b0, 1'b1});
        t.push_back('{4'b0101, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2, 1'b0, 1'b0});
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i].r, t[i].rdy, t[i].sel, t[i].tr, t[i].bu, t[i].lk);
            vectors++;
            if ({addr_in_port, no_port, burst_hold} !== {2'(t[i].eo), t[i].enp, t[i].eh}) begin
                miscompares++;
                $display("FAIL burst_step%0d: got addr=%0d no_port=%b hold=%b, want addr=%0d no_port=%b hold=%b", i, addr_in_port, no_port, burst_hold, t[i].eo, t[i].enp, t[i].eh);
            end
        end
    endtask

    task automatic test_lock();
        vec_t t[$];
        do_reset();
        t.push_back('{4'b0100, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2, 1'b0, 1'b0});
        t.push_back('{4'b1011, 1'b1, 1'b1, 2'b10, 3'b011, 1'b1, 2, 1'b0, 1'b0});
        for (int k = 0; k < 4; k++)
            t.push_back('{4'b1011, 1'b1, 1'b1, 2'b11, 3'b011, 1'b1, 2, 1'b0, 1'b0});
        t.push_back('{4'b1011, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 3, 1'b0, 1'b0});
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i].r, t[i].rdy, t[i].sel, t[i].tr, t[i].bu, t[i].lk);
            vectors++;
            if ({addr_in_port, no_port, burst_hold} !== {2'(t[i].eo), t[i].enp, t[i].eh}) begin
                miscompares++;
                $display("FAIL lock_step%0d: got addr=%0d no_port=%b hold=%b, want addr=%0d no_port=%b hold=%b", i, addr_in_port, no_port, burst_hold, t[i].eo, t[i].enp, t[i].eh);
            end
        end
    endtask

    task automatic test_grant_limit();
        int eo;
        do_reset();
        drive(4'b0100, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            drive(4'b0101, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0);
            eo = (i == 9 && LIMIT_ON) ? 0 : 2;
            vectors++;
            if ({addr_in_port, no_port, burst_hold} !== {2'(eo), 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL grant_limit_nonseq%0d: got addr=%0d no_port=%b hold=%b, want addr=%0d no_port=0 hold=0", i, addr_in_port, no_port, burst_hold, eo);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b0001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        drive(4'b0001, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0);
        drive(4'b0001, 1'b1, 1'b1, 2'b11, 3'b101, 1'b0);
        drive(4'b0001, 1'b1, 1'b1, 2'b11, 3'b101, 1'b0);
        vectors++;
        if ({no_port, burst_hold} !== 2'b01) begin
            miscompares++;
            $display("FAIL async_pre_burst: got no_port=%b hold=%b, want no_port=0 hold=1", no_port, burst_hold);
        end
        #3;
        HRESETn = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({addr_in_port, no_port, burst_hold} !== {2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset_midburst: got addr=%0d no_port=%b hold=%b, want addr=0 no_port=1 hold=0", addr_in_port, no_port, burst_hold);
        end
        #2;
        HRESETn = 1'b1;
        drive(4'b0110, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        vectors++;
        if ({addr_in_port, no_port, burst_hold} !== {2'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_post_reset_arb: got addr=%0d no_port=%b hold=%b, want addr=1 no_port=0 hold=0", addr_in_port, no_port, burst_hold);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rdy, sel, lk;
        logic [1:0] tr;
        logic [2:0] bu;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r   = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            sel = 1'($urandom_range(0, 1));
            tr  = 2'($urandom_range(0, 3));
            bu  = 3'($urandom_range(0, 7));
            lk  = ($urandom_range(0, 11) == 0);
            drive(r, rdy, sel, tr, bu, lk);
            vectors++;
            if ({addr_in_port, no_port, burst_hold} !== {2'(m_owner), m_noport, m_hold}) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got addr=%0d no_port=%b hold=%b, want addr=%0d no_port=%b hold=%b", i, addr_in_port, no_port, burst_hold, m_owner, m_noport, m_hold);
            end
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        req_port = 4'b0; HREADYM = 1'b0; HSELM = 1'b0; HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_round_robin();
        test_burst();
        test_lock();
        test_grant_limit();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
